debug_slave_cmd_queue: RTL and testbench

DEBUG_SLAVE_CMD_QUEUE -- requirements
Module: debug_slave_cmd_queue

---
 rtl/debug_slave_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 43 ++++
 rtl/debug_slave_cmd_queue.sv | 119 +++++++++++
 tb/tb_debug_slave_cmd_queue.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_slave_pkg.sv
// Shared constants and the command record for the debug slave command queue.
// cmd_t describes one queue entry at the default widths.
package debug_slave_pkg;

    localparam int SR_W_DEF  = 38;
    localparam int IR_W_DEF  = 2;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings a TCK-domain level into the clk domain and emits a one-cycle pulse per rising edge.
// The detector stays disarmed after reset until a genuine low has come through the synchronizer.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic       armed_q, armed_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        // fill_q[1] marks sync2_q as holding a real sample rather than the reset zero
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Turns JTAG update-DR/update-IR events into a FIFO of {ir, data} commands for the clk domain,
// with a one-hot action pulse on each pop and a sticky overflow flag for dropped commands.
module debug_slave_cmd_queue
    import debug_slave_pkg::*;
#(
    parameter int SR_W  = SR_W_DEF,
    parameter int IR_W  = IR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vs_udr,
    input  logic                         vs_uir,
    input  logic [IR_W-1:0]              ir_in,
    input  logic [SR_W-1:0]              sr,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [IR_W-1:0]              cmd_ir,
    output logic [SR_W-1:0]              cmd_data,
    output logic [2**IR_W-1:0]           take_action,
    output logic                         ir_update,
    output logic [IR_W-1:0]              ir_latched,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         overflow_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int ACT_W = 2**IR_W;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             ir_update_q, ir_update_d;
    logic [IR_W-1:0]  ir_latched_q, ir_latched_d;

    logic udr_rise;
    logic uir_rise;
    logic pop;
    logic full;
    logic push_ok;

    sync_edge_det u_udr_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    sync_edge_det u_uir_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    always_comb begin
        pop      = (level_q != '0) && cmd_ready;
        full     = (level_q == LVL_W'(DEPTH));
        // A full queue still takes a push when the head leaves in the same cycle
        push_ok  = udr_rise && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{ir: ir_in, data: sr};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d      = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        overflow_d   = (udr_rise && !push_ok) || (overflow_q && !overflow_clr);
        ir_update_d  = uir_rise;
        ir_latched_d = uir_rise ? ir_in : ir_latched_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            ir_update_q  <= 1'b0;
            ir_latched_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            ir_update_q  <= ir_update_d;
            ir_latched_q <= ir_latched_d;
        end
    end

    // Entry contents are only meaningful below level, so storage needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd_valid   = (level_q != '0);
    assign cmd_ir      = mem_q[rd_ptr_q].ir;
    assign cmd_data    = mem_q[rd_ptr_q].data;
    assign take_action = (pop && !reset) ? (ACT_W'(1) << cmd_ir) : '0;
    assign ir_update   = ir_update_q;
    assign ir_latched  = ir_latched_q;
    assign level       = level_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed and randomized checks of debug_slave_cmd_queue against a queue-based reference model.
// Inputs change just after the falling edge; outputs are compared at the falling edge.
`timescale 1ns/1ps
module tb_debug_slave_cmd_queue;
    import debug_slave_pkg::*;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;
    localparam int ACT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             vs_udr;
    logic             vs_uir;
    logic [IR_W-1:0]  ir_in;
    logic [SR_W-1:0]  sr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IR_W-1:0]  cmd_ir;
    logic [SR_W-1:0]  cmd_data;
    logic [ACT_W-1:0] take_action;
    logic             ir_update;
    logic [IR_W-1:0]  ir_latched;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             overflow_clr;

    int checks   = 0;
    int failures = 0;

    // Reference model: command FIFO plus post-reset sample histories of the two update levels
    cmd_t            mq[$];
    bit              udr_s[$];
    bit              uir_s[$];
    bit              m_ovf;
    bit              m_iru;
    logic [IR_W-1:0] m_irl;

    debug_slave_cmd_queue #(.SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .ir_in        (ir_in),
        .sr           (sr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ir       (cmd_ir),
        .cmd_data     (cmd_data),
        .take_action  (take_action),
        .ir_update    (ir_update),
        .ir_latched   (ir_latched),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // A level seen high two edges ago after a real low three edges ago is a rising edge landing now
    task automatic model_edge();
        bit udr_rise;
        bit uir_rise;
        bit do_pop;
        bit full;
        if (reset) begin
            mq.delete();
            udr_s.delete();
            uir_s.delete();
            m_ovf = 1'b0;
            m_iru = 1'b0;
            m_irl = '0;
            return;
        end
        udr_rise = (udr_s.size() >= 3) && udr_s[udr_s.size()-2] && !udr_s[udr_s.size()-3];
        uir_rise = (uir_s.size() >= 3) && uir_s[uir_s.size()-2] && !uir_s[uir_s.size()-3];
        do_pop   = (mq.size() > 0) && cmd_ready;
        full     = (mq.size() == DEPTH) && !do_pop;
        if (do_pop) void'(mq.pop_front());
        if (udr_rise && !full) mq.push_back(cmd_t'{ir: ir_in, data: sr});
        if (udr_rise && full) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        m_iru = uir_rise;
        if (uir_rise) m_irl = ir_in;
        udr_s.push_back(vs_udr);
        uir_s.push_back(vs_uir);
        if (udr_s.size() > 4) void'(udr_s.pop_front());
        if (uir_s.size() > 4) void'(uir_s.pop_front());
    endtask

    function automatic logic [ACT_W-1:0] exp_take();
        if (!reset && mq.size() > 0 && cmd_ready) return ACT_W'(1) << mq[0].ir;
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data,
                             input int hi, input int lo);
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        repeat (hi) step();
        vs_udr = 1'b0;
        repeat (lo) step();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        vs_udr       = 1'b0;
        vs_uir       = 1'b0;
        cmd_ready    = 1'b1;
        overflow_clr = 1'b0;
        ir_in        = 2'($urandom);
        sr           = {6'($urandom), $urandom};
        #1;
        checks++;
        if (take_action !== '0) begin
            failures++;
            $display("[TB] FAIL reset_take_action got=%b exp=0000", take_action);
        end
        repeat (3) step();
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_cmd_valid got=%b exp=0", cmd_valid);
        end
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_level got=%0d exp=0", level);
        end
        checks++;
        if (overflow !== 1'b0 || ir_update !== 1'b0 || ir_latched !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_flags got ovf=%b iru=%b irl=%b exp 0/0/00", overflow, ir_update, ir_latched);
        end
        reset     = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_single_push();
        ir_in  = 2'b01;
        sr     = 38'h0_1234_5678;
        vs_udr = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            checks++;
            if (cmd_valid !== (e >= 2)) begin
                failures++;
                $display("[TB] FAIL push_latency_edge%0d got=%b exp=%b", e, cmd_valid, (e >= 2));
            end
        end
        vs_udr = 1'b0;
        repeat (3) step();
        checks++;
        if (cmd_data !== 38'h0_1234_5678 || cmd_ir !== 2'b01) begin
            failures++;
            $display("[TB] FAIL push_head got ir=%b data=%h exp ir=01 data=0012345678", cmd_ir, cmd_data);
        end
        checks++;
        if (level !== 3'd1 || level !== LVL_W'(mq.size())) begin
            failures++;
            $display("[TB] FAIL push_level got=%0d exp=1 model=%0d", level, mq.size());
        end
    endtask

    task automatic test_pop();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        pulse_udr(2'b11, {6'($urandom), $urandom}, 2, 3);
        cmd_ready = 1'b1;
        #1;
        checks++;
        if (take_action !== 4'b1000 || take_action !== exp_take()) begin
            failures++;
            $display("[TB] FAIL pop_take_action got=%b exp=1000", take_action);
        end
        step();
        checks++;
        if (take_action !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL pop_take_after got=%b exp=0000", take_action);
        end
        checks++;
        if (level !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pop_empty got level=%0d valid=%b exp 0/0", level, cmd_valid);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 5; d++) pulse_udr(2'b00, SR_W'(d), 2, 2);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_fill got level=%0d ovf=%b exp 4/1", level, overflow);
        end
        // A drop coinciding with overflow_clr must leave the flag set
        sr     = SR_W'(6);
        vs_udr = 1'b1;
        step();
        step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        vs_udr       = 1'b0;
        checks++;
        if (overflow !== 1'b1 || overflow !== m_ovf || level !== 3'd4) begin
            failures++;
            $display("[TB] FAIL ovf_drop_clr got ovf=%b level=%0d exp 1/4", overflow, level);
        end
        step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear got=%b exp=0", overflow);
        end
        cmd_ready = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            checks++;
            if (cmd_data !== SR_W'(d)) begin
                failures++;
                $display("[TB] FAIL ovf_order%0d got=%0d exp=%0d", d, cmd_data, d);
            end
            step();
        end
        cmd_ready = 1'b0;
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("[TB] FAIL ovf_drained got=%0d exp=0", level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [SR_W-1:0] exp_seq [4];
        for (int d = 1; d <= 4; d++) pulse_udr(2'b00, SR_W'(d), 2, 2);
        sr     = 38'h2A_AAAA_AAAA;
        vs_udr = 1'b1;
        step();
        step();
        cmd_ready = 1'b1;
        #1;
        checks++;
        if (take_action !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL full_pop_take got=%b exp=0001", take_action);
        end
        step();
        cmd_ready = 1'b0;
        vs_udr    = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_push_pop got level=%0d ovf=%b exp 4/0", level, overflow);
        end
        exp_seq = '{SR_W'(2), SR_W'(3), SR_W'(4), 38'h2A_AAAA_AAAA};
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_data !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL full_order%0d got=%h exp=%h", i, cmd_data, exp_seq[i]);
            end
            step();
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset_held();
        vs_udr = 1'b1;
        reset  = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (6) step();
        checks++;
        if (level !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_no_push got level=%0d valid=%b exp 0/0", level, cmd_valid);
        end
        vs_udr = 1'b0;
        repeat (3) step();
        vs_udr = 1'b1;
        repeat (4) step();
        vs_udr = 1'b0;
        repeat (2) step();
        checks++;
        if (level !== 3'd1) begin
            failures++;
            $display("[TB] FAIL held_rearm got=%0d exp=1", level);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        int base;
        base   = mq.size();
        ir_in  = 2'b10;
        sr     = {6'($urandom), $urandom};
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        step();
        step();
        checks++;
        if (ir_update !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_early got=%b exp=0", ir_update);
        end
        step();
        checks++;
        if (ir_update !== 1'b1 || ir_latched !== 2'b10) begin
            failures++;
            $display("[TB] FAIL simul_ir got iru=%b irl=%b exp 1/10", ir_update, ir_latched);
        end
        checks++;
        if (level !== LVL_W'(base + 1)) begin
            failures++;
            $display("[TB] FAIL simul_level got=%0d exp=%0d", level, base + 1);
        end
        step();
        checks++;
        if (ir_update !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_pulse_width got=%b exp=0", ir_update);
        end
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_mid_reset();
        for (int d = 0; d < 3; d++) pulse_udr(2'($urandom), {6'($urandom), $urandom}, 2, 2);
        cmd_ready = 1'b1;
        reset     = 1'b1;
        #1;
        checks++;
        if (take_action !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_take got=%b exp=0000", take_action);
        end
        step();
        checks++;
        if (level !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_flush got level=%0d valid=%b exp 0/0", level, cmd_valid);
        end
        reset     = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
            if (!vs_udr && !vs_uir) begin
                ir_in = 2'($urandom);
                sr    = {6'($urandom), $urandom};
            end
            cmd_ready    = ($urandom_range(0, 9) < (((c / 100) % 2 == 0) ? 1 : 6));
            overflow_clr = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 249) == 0);
            #1;
            checks++;
            if (take_action !== exp_take()) begin
                failures++;
                $display("[TB] FAIL rand_take c=%0d got=%b exp=%b", c, take_action, exp_take());
            end
            step();
            checks++;
            if (level !== LVL_W'(mq.size()) || cmd_valid !== (mq.size() > 0)) begin
                failures++;
                $display("[TB] FAIL rand_level c=%0d got=%0d/%b exp=%0d", c, level, cmd_valid, mq.size());
            end
            checks++;
            if (overflow !== m_ovf) begin
                failures++;
                $display("[TB] FAIL rand_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf);
            end
            checks++;
            if (ir_update !== m_iru || ir_latched !== m_irl) begin
                failures++;
                $display("[TB] FAIL rand_ir c=%0d got=%b/%b exp=%b/%b", c, ir_update, ir_latched, m_iru, m_irl);
            end
            if (mq.size() > 0) begin
                checks++;
                if (cmd_ir !== mq[0].ir || cmd_data !== mq[0].data) begin
                    failures++;
                    $display("[TB] FAIL rand_head c=%0d got=%b/%h exp=%b/%h", c, cmd_ir, cmd_data, mq[0].ir, mq[0].data);
                end
            end
        end
        reset        = 1'b0;
        overflow_clr = 1'b0;
        cmd_ready    = 1'b0;
        vs_udr       = 1'b0;
        vs_uir       = 1'b0;
        step();
    endtask

    initial begin
        $display("[TB] starting debug_slave_cmd_queue bench");
        test_reset();
        test_single_push();
        test_pop();
        test_overflow();
        test_full_push_pop();
        test_reset_held();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
